// File: rtl/alu_8bit.sv
// alu_8bit: registered arithmetic/logic unit.
//
// Operands a/b and opcode alu_sel are sampled on a rising clk edge while
// in_valid is high. The result, carry and divide-by-zero flag are registered
// and presented after that same edge, with out_valid high for one cycle.
// While in_valid is low, out_valid drops and the data outputs hold.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset, clears every output
//   a, b         operands (WIDTH bits, unsigned)
//   alu_sel      4-bit opcode
//   in_valid     sample qualifier
//   alu_out      registered result
//   carry_out    registered carry / borrow / shift-out flag
//   out_valid    one-cycle strobe per accepted operation
//   div_by_zero  registered; set with the result of a divide by zero
//
// Optional build macro ALU_STATUS_EN adds registered zero_flag and ovf_flag
// (signed overflow for add/sub only).
module alu_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             out_valid,
`ifdef ALU_STATUS_EN
    output logic             zero_flag,
    output logic             ovf_flag,
`endif
    output logic             div_by_zero
);

    localparam int unsigned Msb = WIDTH - 1;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic               b_is_zero;

    logic [WIDTH-1:0]   result_d;
    logic               carry_d;
    logic               dbz_d;

    logic [WIDTH-1:0]   alu_out_q;
    logic               carry_out_q;
    logic               out_valid_q;
    logic               dbz_q;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        // Top bit of the widened difference is the borrow (a < b).
        diff      = {1'b0, a} - {1'b0, b};
        prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        b_is_zero = (b == '0);
    end

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        dbz_d    = 1'b0;
        case (alu_sel)
            4'h0: begin
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
            end
            4'h1: begin
                result_d = diff[WIDTH-1:0];
                carry_d  = diff[WIDTH];
            end
            4'h2: begin
                result_d = prod[WIDTH-1:0];
                carry_d  = |prod[2*WIDTH-1:WIDTH];
            end
            4'h3: begin
                // Guarded so a zero divisor never produces X.
                result_d = b_is_zero ? '1 : (a / b);
                dbz_d    = b_is_zero;
            end
            4'h4: begin
                result_d = {a[WIDTH-2:0], 1'b0};
                carry_d  = a[Msb];
            end
            4'h5: begin
                result_d = {1'b0, a[WIDTH-1:1]};
                carry_d  = a[0];
            end
            4'h6: result_d = {a[WIDTH-2:0], a[Msb]};
            4'h7: result_d = {a[0], a[WIDTH-1:1]};
            4'h8: result_d = a & b;
            4'h9: result_d = a | b;
            4'hA: result_d = a ^ b;
            4'hB: result_d = ~(a | b);
            4'hC: result_d = ~(a & b);
            4'hD: result_d = ~(a ^ b);
            4'hE: result_d = {{(WIDTH-1){1'b0}}, (a > b)};
            4'hF: result_d = {{(WIDTH-1){1'b0}}, (a == b)};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q   <= '0;
            carry_out_q <= 1'b0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                alu_out_q   <= result_d;
                carry_out_q <= carry_d;
                dbz_q       <= dbz_d;
            end
        end
    end

    assign alu_out     = alu_out_q;
    assign carry_out   = carry_out_q;
    assign out_valid   = out_valid_q;
    assign div_by_zero = dbz_q;

`ifdef ALU_STATUS_EN
    logic ovf_d;
    logic zero_q;
    logic ovf_q;

    // Signed overflow: add overflows when like-signed operands give an
    // unlike-signed sum; sub when unlike-signed operands flip a's sign.
    always_comb begin
        ovf_d = 1'b0;
        if (alu_sel == 4'h0) begin
            ovf_d = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
        end else if (alu_sel == 4'h1) begin
            ovf_d = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (in_valid) begin
            zero_q <= (result_d == '0);
            ovf_q  <= ovf_d;
        end
    end

    assign zero_flag = zero_q;
    assign ovf_flag  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed test-plan vectors, back-to-back
// random operations checked against a behavioural model, hold behaviour and
// asynchronous reset. Expected results go into a scoreboard queue when an
// operation is driven and are popped when the DUT presents the result.
module tb_alu_8bit;

    typedef struct packed {
        logic [7:0] res;
        logic       carry;
        logic       dbz;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] alu_sel;
    logic       in_valid;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       out_valid;
    logic       div_by_zero;
`ifdef ALU_STATUS_EN
    logic       zero_flag;
    logic       ovf_flag;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last_exp;

    alu_8bit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .alu_sel    (alu_sel),
        .in_valid   (in_valid),
        .alu_out    (alu_out),
        .carry_out  (carry_out),
        .out_valid  (out_valid),
`ifdef ALU_STATUS_EN
        .zero_flag  (zero_flag),
        .ovf_flag   (ovf_flag),
`endif
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference written from the opcode table.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic [3:0] s);
        exp_t e;
        int   ix = int'(x);
        int   iy = int'(y);
        e = '0;
        case (s)
            4'h0: begin e.res = 8'((ix + iy) % 256); e.carry = (ix + iy) > 255; end
            4'h1: begin e.res = 8'((ix - iy + 256) % 256); e.carry = ix < iy; end
            4'h2: begin e.res = 8'((ix * iy) % 256); e.carry = (ix * iy) > 255; end
            4'h3: begin
                if (iy == 0) begin e.res = 8'hFF; e.dbz = 1'b1; end
                else e.res = 8'(ix / iy);
            end
            4'h4: begin e.res = 8'((ix * 2) % 256); e.carry = ix >= 128; end
            4'h5: begin e.res = 8'(ix / 2); e.carry = (ix % 2) == 1; end
            4'h6: e.res = 8'(((ix * 2) % 256) + ix / 128);
            4'h7: e.res = 8'(ix / 2 + (ix % 2) * 128);
            4'h8: e.res = x & y;
            4'h9: e.res = x | y;
            4'hA: e.res = x ^ y;
            4'hB: e.res = ~(x | y);
            4'hC: e.res = ~(x & y);
            4'hD: e.res = ~(x ^ y);
            4'hE: e.res = (ix > iy) ? 8'h01 : 8'h00;
            default: e.res = (ix == iy) ? 8'h01 : 8'h00;
        endcase
        return e;
    endfunction

    // Drive one operation and record its expected outcome.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [3:0] s,
                         input exp_t e);
        a        = x;
        b        = y;
        alu_sel  = s;
        in_valid = 1'b1;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        alu_sel  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({alu_out, carry_out, out_valid, div_by_zero} !== 11'h0) begin
            errors++;
            $display("FAIL reset_state: got out=%h c=%b v=%b dz=%b, expected all 0",
                     alu_out, carry_out, out_valid, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_arith;
        logic [7:0] ta[7]  = '{8'hF0, 8'h12, 8'h05, 8'h07, 8'h10, 8'h64, 8'h64};
        logic [7:0] tb_[7] = '{8'h20, 8'h34, 8'h07, 8'h05, 8'h20, 8'h07, 8'h00};
        logic [3:0] ts[7]  = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h3};
        exp_t       te[7]  = '{{8'h10, 1'b1, 1'b0}, {8'h46, 1'b0, 1'b0},
                               {8'hFE, 1'b1, 1'b0}, {8'h02, 1'b0, 1'b0},
                               {8'h00, 1'b1, 1'b0}, {8'h0E, 1'b0, 1'b0},
                               {8'hFF, 1'b0, 1'b1}};
        exp_t       e;
        for (int i = 0; i < 7; i++) begin
            issue(ta[i], tb_[i], ts[i], te[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({out_valid, alu_out, carry_out, div_by_zero} !== {1'b1, e.res, e.carry, e.dbz})
            begin
                errors++;
                $display("FAIL arith[%0d] sel=%h: got v=%b out=%h c=%b dz=%b, expected v=1 out=%h c=%b dz=%b",
                         i, ts[i], out_valid, alu_out, carry_out, div_by_zero,
                         e.res, e.carry, e.dbz);
            end
            last_exp = e;
        end
    endtask

    task automatic test_shift_logic;
        logic [7:0] ta[11]  = '{8'h81, 8'h81, 8'h81, 8'h81, 8'hCC, 8'hCC, 8'hCC,
                                8'hCC, 8'hCC, 8'hCC, 8'h3C};
        logic [7:0] tb_[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hAA, 8'hAA,
                                8'hAA, 8'hAA, 8'hAA, 8'h3C};
        logic [3:0] ts[11]  = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA,
                                4'hB, 4'hC, 4'hD, 4'hF};
        logic [7:0] tr[11]  = '{8'h02, 8'h40, 8'h03, 8'hC0, 8'h88, 8'hEE, 8'h66,
                                8'h11, 8'h77, 8'h99, 8'h01};
        logic       tc[11]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0};
        exp_t       e;
        for (int i = 0; i < 12; i++) begin
            if (i < 11) issue(ta[i], tb_[i], ts[i], '{tr[i], tc[i], 1'b0});
            else        issue(8'h3C, 8'h3C, 4'hE, '{8'h00, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({out_valid, alu_out, carry_out, div_by_zero} !== {1'b1, e.res, e.carry, e.dbz})
            begin
                errors++;
                $display("FAIL shift_logic[%0d] sel=%h: got v=%b out=%h c=%b dz=%b, expected v=1 out=%h c=%b dz=%b",
                         i, alu_sel, out_valid, alu_out, carry_out, div_by_zero,
                         e.res, e.carry, e.dbz);
            end
            last_exp = e;
        end
    endtask

    // Random operations on consecutive edges; a result must appear each cycle.
    task automatic test_back_to_back;
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] s;
        exp_t       e;
        for (int i = 0; i < 48; i++) begin
            x = 8'($urandom);
            y = (i % 8 == 3) ? 8'h00 : 8'($urandom);
            s = 4'(i % 16);
            issue(x, y, s, model(x, y, s));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({out_valid, alu_out, carry_out, div_by_zero} !== {1'b1, e.res, e.carry, e.dbz})
            begin
                errors++;
                $display("FAIL back_to_back[%0d] a=%h b=%h sel=%h: got v=%b out=%h c=%b dz=%b, expected v=1 out=%h c=%b dz=%b",
                         i, x, y, s, out_valid, alu_out, carry_out, div_by_zero,
                         e.res, e.carry, e.dbz);
            end
            last_exp = e;
        end
    endtask

    task automatic test_hold;
        in_valid = 1'b0;
        a        = 8'h5A;
        b        = 8'h00;
        alu_sel  = 4'h3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, alu_out, carry_out, div_by_zero} !==
                {1'b0, last_exp.res, last_exp.carry, last_exp.dbz}) begin
                errors++;
                $display("FAIL hold[%0d]: got v=%b out=%h c=%b dz=%b, expected v=0 out=%h c=%b dz=%b",
                         i, out_valid, alu_out, carry_out, div_by_zero,
                         last_exp.res, last_exp.carry, last_exp.dbz);
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        issue(8'hF0, 8'h20, 4'h0, '{8'h10, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({out_valid, alu_out, carry_out} !== {1'b1, e.res, e.carry}) begin
            errors++;
            $display("FAIL pre_reset_op: got v=%b out=%h c=%b, expected v=1 out=%h c=%b",
                     out_valid, alu_out, carry_out, e.res, e.carry);
        end
        // Another op in flight, then reset lands between edges.
        issue(8'h64, 8'h00, 4'h3, '{8'hFF, 1'b0, 1'b1});
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({alu_out, carry_out, out_valid, div_by_zero} !== 11'h0) begin
            errors++;
            $display("FAIL async_reset: got out=%h c=%b v=%b dz=%b, expected all 0",
                     alu_out, carry_out, out_valid, div_by_zero);
        end
        @(posedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, alu_out, div_by_zero} !== 10'h0) begin
                errors++;
                $display("FAIL post_reset_idle[%0d]: got v=%b out=%h dz=%b, expected v=0 out=00 dz=0",
                         i, out_valid, alu_out, div_by_zero);
            end
        end
        issue(8'h07, 8'h05, 4'h1, '{8'h02, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({out_valid, alu_out, carry_out} !== {1'b1, e.res, e.carry}) begin
            errors++;
            $display("FAIL post_reset_op: got v=%b out=%h c=%b, expected v=1 out=%h c=%b",
                     out_valid, alu_out, carry_out, e.res, e.carry);
        end
        in_valid = 1'b0;
    endtask

`ifdef ALU_STATUS_EN
    task automatic test_status;
        issue(8'h7F, 8'h01, 4'h0, '{8'h80, 1'b0, 1'b0});
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        checks++;
        if ({alu_out, ovf_flag, zero_flag} !== {8'h80, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL status_ovf: got out=%h ovf=%b zero=%b, expected out=80 ovf=1 zero=0",
                     alu_out, ovf_flag, zero_flag);
        end
        issue(8'hF0, 8'h10, 4'h0, '{8'h00, 1'b1, 1'b0});
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        checks++;
        if ({alu_out, ovf_flag, zero_flag} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL status_zero: got out=%h ovf=%b zero=%b, expected out=00 ovf=0 zero=1",
                     alu_out, ovf_flag, zero_flag);
        end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_shift_logic();
        test_back_to_back();
        test_hold();
        test_async_reset();
`ifdef ALU_STATUS_EN
        test_status();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
